// File: rtl/ecc_pkg.sv
// ----------------------------------------------------------------------------
// ecc_pkg
// Shared definitions for the 8-bit SECDED channel (Hamming(12,8) plus an
// overall parity bit, 13-bit codeword). Used by the receive-side decoder and
// by the transmit-side encoder.
//
// Codeword layout:
//   bit 0            overall parity (XOR of all 13 bits is 0)
//   bits 1,2,4,8     Hamming check bits
//   bits 3,5,6,7,9,10,11,12  data bits d0..d7
//
// Contents: width constants, codeword/data/syndrome types, the error-class
// enum, and helper functions for syndrome, parity, correction, data
// extraction and encoding.
// ----------------------------------------------------------------------------
package ecc_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ECC_WIDTH  = 5;
    localparam int CODE_WIDTH = DATA_WIDTH + ECC_WIDTH;
    localparam int SYN_WIDTH  = 4;

    typedef logic [CODE_WIDTH-1:0] code_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [SYN_WIDTH-1:0]  syn_t;

    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } err_class_t;

    // Hamming position of data bit idx.
    function automatic syn_t data_pos(input int unsigned idx);
        syn_t pos;
        case (idx)
            32'd0:   pos = 4'd3;
            32'd1:   pos = 4'd5;
            32'd2:   pos = 4'd6;
            32'd3:   pos = 4'd7;
            32'd4:   pos = 4'd9;
            32'd5:   pos = 4'd10;
            32'd6:   pos = 4'd11;
            32'd7:   pos = 4'd12;
            default: pos = 4'd0;
        endcase
        return pos;
    endfunction

    // Syndrome bit k is the parity of every position whose index has bit k
    // set; check bit 2^k is one of those positions.
    function automatic syn_t calc_syndrome(input code_t code);
        syn_t syn;
        syn_t pos;
        syn = 4'd0;
        for (int k = 0; k < SYN_WIDTH; k++) begin
            for (int i = 1; i < CODE_WIDTH; i++) begin
                pos = syn_t'(i);
                if (pos[k]) begin
                    syn[k] = syn[k] ^ code[i];
                end
            end
        end
        return syn;
    endfunction

    // Overall parity across all 13 bits; 1 means an odd number of flips.
    function automatic logic calc_parity(input code_t code);
        return ^code;
    endfunction

    // Gather the data bits from their Hamming positions.
    function automatic data_t extract_data(input code_t code);
        data_t data;
        data = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            data[j] = code[data_pos(j)];
        end
        return data;
    endfunction

    // Invert the bit at Hamming position syn; syndromes outside 1..12 leave
    // the word untouched.
    function automatic code_t flip_position(input code_t code, input syn_t syn);
        code_t fixed;
        fixed = code;
        if ((syn != 4'd0) && (syn <= 4'(CODE_WIDTH - 1))) begin
            fixed[syn] = ~code[syn];
        end
        return fixed;
    endfunction

    // Map syndrome and overall parity to an error class. An odd flip count
    // with a syndrome pointing past position 12 cannot be a single error.
    function automatic err_class_t classify(input syn_t syn, input logic par);
        err_class_t cls;
        if (!par) begin
            cls = (syn == 4'd0) ? CLEAN : UNCORR;
        end else begin
            cls = (syn <= 4'(CODE_WIDTH - 1)) ? CORR : UNCORR;
        end
        return cls;
    endfunction

    // Build a codeword from data: scatter the data, fill check bits so the
    // syndrome becomes zero, then set overall parity.
    function automatic code_t encode(input data_t data);
        code_t code;
        syn_t  syn;
        code = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            code[data_pos(j)] = data[j];
        end
        syn = calc_syndrome(code);
        for (int k = 0; k < SYN_WIDTH; k++) begin
            code[1 << k] = syn[k];
        end
        code[0] = ^code[CODE_WIDTH-1:1];
        return code;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// ----------------------------------------------------------------------------
// secded_syndrome
// Purely combinational syndrome and overall-parity generator for a 13-bit
// SECDED codeword.
//
// Ports:
//   code      in   13  received codeword
//   syndrome  out  4   Hamming syndrome (0 = no Hamming error, 1..12 = position)
//   parity    out  1   XOR of all 13 codeword bits
// ----------------------------------------------------------------------------
module secded_syndrome
    import ecc_pkg::*;
(
    input  logic [CODE_WIDTH-1:0] code,
    output logic [SYN_WIDTH-1:0]  syndrome,
    output logic                  parity
);

    assign syndrome = calc_syndrome(code);
    assign parity   = calc_parity(code);

endmodule

// File: rtl/secded_rx_decoder.sv
// ----------------------------------------------------------------------------
// secded_rx_decoder
// Receive-side SECDED decoder for the 8-bit data channel. Corrects single-bit
// errors, flags double-bit errors and invalid syndromes, and delivers data
// plus flags through a 2-stage stall-all pipeline.
//
// Optional feature macro: ECC_STATS_EN
//   defined   -> saturating corrected/uncorrectable word counters
//   undefined -> counters tied to 0, cnt_clr ignored
//
// Parameters:
//   DATA_WIDTH  payload width (only 8 supported)
//   ECC_WIDTH   check bits (only 5 supported)
//   CNT_WIDTH   statistics counter width
//
// Ports:
//   clk              in   1          clock, rising edge
//   rst              in   1          synchronous active-high reset
//   in_code          in   13         received codeword
//   in_valid         in   1          in_code valid
//   in_ready         out  1          decoder accepts in_code this cycle
//   out_data         out  8          decoded (corrected if possible) data
//   out_valid        out  1          out_data and flags valid
//   out_ready        in   1          downstream accepts this cycle
//   error_detected   out  1          any error found in this word
//   error_corrected  out  1          single error found and corrected
//   corr_count       out  CNT_WIDTH  corrected-word count
//   uncorr_count     out  CNT_WIDTH  uncorrectable-word count
//   cnt_clr          in   1          synchronous counter clear
// ----------------------------------------------------------------------------
module secded_rx_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ECC_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]  in_code,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             error_detected,
    output logic                             error_corrected,
    output logic [CNT_WIDTH-1:0]             corr_count,
    output logic [CNT_WIDTH-1:0]             uncorr_count,
    input  logic                             cnt_clr
);

    import ecc_pkg::*;

    if ((DATA_WIDTH != ecc_pkg::DATA_WIDTH) || (ECC_WIDTH != ecc_pkg::ECC_WIDTH)) begin : g_bad_width
        $error("secded_rx_decoder supports only DATA_WIDTH=8 and ECC_WIDTH=5");
    end

    // Pipeline control
    logic                  advance_s;

    // Stage 1 registers
    logic                  s1_valid_r;
    logic [CODE_WIDTH-1:0] s1_code_r;
    logic [SYN_WIDTH-1:0]  s1_syn_r;
    logic                  s1_par_r;

    // Syndrome of the incoming word
    logic [SYN_WIDTH-1:0]  syn_s;
    logic                  par_s;

    // Stage 2 decode results
    err_class_t            err_class_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  det_s;
    logic                  cor_s;

    secded_syndrome u_syndrome (
        .code     (in_code),
        .syndrome (syn_s),
        .parity   (par_s)
    );

    // Stall-all: every stage moves together whenever the output slot is free
    // or being drained, so a bubble in stage 1 is overwritten rather than held.
    assign advance_s = out_ready | ~out_valid;
    assign in_ready  = rst | advance_s;

    // Stage 1: capture codeword, syndrome and parity
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_code_r  <= '0;
            s1_syn_r   <= '0;
            s1_par_r   <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            s1_code_r  <= in_code;
            s1_syn_r   <= syn_s;
            s1_par_r   <= par_s;
        end
    end

    // Classify the stage-1 word and form the corrected data and flags
    always_comb begin
        err_class_s = classify(s1_syn_r, s1_par_r);
        data_s      = extract_data(s1_code_r);
        det_s       = 1'b0;
        cor_s       = 1'b0;
        case (err_class_s)
            CLEAN: begin
                det_s = 1'b0;
                cor_s = 1'b0;
            end
            CORR: begin
                // Syndrome 0 with odd parity is the parity bit itself; the
                // flip helper leaves the data positions alone in that case.
                data_s = extract_data(flip_position(s1_code_r, s1_syn_r));
                det_s  = 1'b1;
                cor_s  = 1'b1;
            end
            UNCORR: begin
                det_s = 1'b1;
                cor_s = 1'b0;
            end
            default: begin
                det_s = 1'b1;
                cor_s = 1'b0;
            end
        endcase
    end

    // Stage 2: output registers, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_data        <= '0;
            error_detected  <= 1'b0;
            error_corrected <= 1'b0;
        end else if (advance_s) begin
            out_valid       <= s1_valid_r;
            out_data        <= data_s;
            error_detected  <= det_s;
            error_corrected <= cor_s;
        end
    end

`ifdef ECC_STATS_EN
    logic                 out_fire_s;
    logic [CNT_WIDTH-1:0] corr_cnt_r;
    logic [CNT_WIDTH-1:0] uncorr_cnt_r;

    assign out_fire_s = out_valid & out_ready;

    // Saturating statistics counters; clear takes priority over a count
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_cnt_r   <= '0;
            uncorr_cnt_r <= '0;
        end else if (cnt_clr) begin
            corr_cnt_r   <= '0;
            uncorr_cnt_r <= '0;
        end else if (out_fire_s) begin
            if (error_corrected && (corr_cnt_r != '1)) begin
                corr_cnt_r <= corr_cnt_r + CNT_WIDTH'(1);
            end
            if (error_detected && !error_corrected && (uncorr_cnt_r != '1)) begin
                uncorr_cnt_r <= uncorr_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    assign corr_count   = corr_cnt_r;
    assign uncorr_count = uncorr_cnt_r;
`else
    logic unused_cnt_clr_s;

    assign unused_cnt_clr_s = cnt_clr;
    assign corr_count       = '0;
    assign uncorr_count     = '0;
`endif

endmodule
